// File: rtl/adc_spi_tx.sv
// adc_spi_tx: buffers ADC samples in a small FIFO and sends each one as a framed SPI word (master, mode 0).
// Optional build macro ADC_SPI_TX_PARITY_EN appends an even-parity bit, giving a 17-bit frame.
module adc_spi_tx #(
  parameter int CLK_DIV = 4,
  parameter int FIFO_AW = 3,
  parameter int GAP_CYC = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [11:0]      smp_data,
  input  logic [2:0]       smp_ch,
  input  logic             smp_valid,
  output logic             spi_clk,
  output logic             spi_mosi,
  output logic             spi_cs,
  input  logic             spi_miso,
  output logic             miso_last,
  output logic [FIFO_AW:0] fifo_level,
  output logic             overflow,
  input  logic             clr_ovf
);

`ifdef ADC_SPI_TX_PARITY_EN
  localparam int FW = 17;
`else
  localparam int FW = 16;
`endif
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYC - 1);
  localparam logic [4:0]  LAST_RISE = 5'(FW);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

  state_t             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [4:0]         rise_q, rise_d;
  logic [FW-1:0]      shift_q, shift_d;
  logic               sclk_q, sclk_d;
  logic               cs_q, cs_d;
  logic               miso_samp_q, miso_samp_d;
  logic               miso_last_q, miso_last_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   level_q, level_d;
  logic               ovf_q, ovf_d;
  logic [15:0]        mem_q [DEPTH];

  logic [15:0]        word_in;
  logic [15:0]        rd_word;
  logic [FW-1:0]      frame;
  logic               full, empty, pop, push, drop;

  assign word_in = {(smp_ch == 3'd0), smp_ch, smp_data};
  assign rd_word = mem_q[rd_ptr_q];
`ifdef ADC_SPI_TX_PARITY_EN
  assign frame = {rd_word, ^rd_word};
`else
  assign frame = rd_word;
`endif

  // Level can never exceed DEPTH, so its top bit alone means full.
  assign full  = level_q[FIFO_AW];
  assign empty = (level_q == '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rise_d      = rise_q;
    shift_d     = shift_q;
    sclk_d      = sclk_q;
    cs_d        = cs_q;
    miso_samp_d = miso_samp_q;
    miso_last_d = miso_last_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        cs_d   = 1'b1;
        sclk_d = 1'b0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = frame;
          cs_d    = 1'b0;
          cnt_d   = '0;
          rise_d  = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d      = 1'b1;
            rise_d      = rise_q + 5'd1;
            miso_samp_d = spi_miso;
          end else begin
            sclk_d = 1'b0;
            // The falling edge after the final rising edge closes the frame instead of shifting.
            if (rise_q == LAST_RISE) begin
              cs_d        = 1'b1;
              miso_last_d = miso_samp_q;
              state_d     = GAP;
            end else begin
              shift_d = {shift_q[FW-2:0], 1'b0};
            end
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A full FIFO still accepts a sample when a pop frees a slot in the same cycle.
  always_comb begin
    push     = smp_valid && (!full || pop);
    drop     = smp_valid && !push;
    wr_ptr_d = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop) begin
      level_d = level_q + (FIFO_AW+1)'(1);
    end else if (pop && !push) begin
      level_d = level_q - (FIFO_AW+1)'(1);
    end
    ovf_d = ovf_q;
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rise_q      <= '0;
      shift_q     <= '0;
      sclk_q      <= 1'b0;
      cs_q        <= 1'b1;
      miso_samp_q <= 1'b0;
      miso_last_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rise_q      <= rise_d;
      shift_q     <= shift_d;
      sclk_q      <= sclk_d;
      cs_q        <= cs_d;
      miso_samp_q <= miso_samp_d;
      miso_last_q <= miso_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_q[wr_ptr_q] <= word_in;
    end
  end

  assign spi_clk    = sclk_q;
  assign spi_cs     = cs_q;
  assign spi_mosi   = shift_q[FW-1];
  assign miso_last  = miso_last_q;
  assign fifo_level = level_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_adc_spi_tx.sv
// tb_adc_spi_tx: scoreboard bench for adc_spi_tx; a monitor rebuilds SPI frames and each test task checks them.
// Honours ADC_SPI_TX_PARITY_EN so the same bench covers the 17-bit parity build.
module tb_adc_spi_tx;
  localparam int CLK_DIV = 4;
  localparam int FIFO_AW = 3;
  localparam int GAP_CYC = 8;
  localparam int DEPTH   = 1 << FIFO_AW;
`ifdef ADC_SPI_TX_PARITY_EN
  localparam int FW = 17;
`else
  localparam int FW = 16;
`endif
  localparam int CS_LOW   = CLK_DIV * (1 + 2 * FW);
  localparam int CS_GAP   = GAP_CYC + 1;
  localparam int FRAME_TO = 1 + CS_LOW + GAP_CYC + 40;

  logic             clk_in = 1'b0;
  logic             rst = 1'b1;
  logic [11:0]      smp_data = '0;
  logic [2:0]       smp_ch = '0;
  logic             smp_valid = 1'b0;
  logic             spi_clk, spi_mosi, spi_cs;
  logic             spi_miso = 1'b0;
  logic             miso_last;
  logic [FIFO_AW:0] fifo_level;
  logic             overflow;
  logic             clr_ovf = 1'b0;

  int vec_cnt = 0;
  int miscompares = 0;

  typedef struct {
    logic [16:0] data;
    int          nbits;
    int          low_cyc;
    int          gap;
  } rx_t;

  rx_t         rx_q[$];
  logic [16:0] exp_q[$];
  int          rise_total = 0;
  int          low_total = 0;

  adc_spi_tx #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW), .GAP_CYC(GAP_CYC)) dut (
    .clk_in(clk_in), .rst(rst), .smp_data(smp_data), .smp_ch(smp_ch), .smp_valid(smp_valid),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_cs(spi_cs), .spi_miso(spi_miso),
    .miso_last(miso_last), .fifo_level(fifo_level), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [16:0] exp_frame(input logic [2:0] ch, input logic [11:0] d);
    logic [15:0] w;
    w = {(ch == 3'd0), ch, d};
    if (FW == 17) return {w, ^w};
    return {1'b0, w};
  endfunction

  // Monitor: samples on the falling clk_in edge and rebuilds frames from MOSI at each spi_clk rise.
  initial begin
    bit          in_frame = 0;
    bit          prev_sclk = 0;
    int          low_cnt = 0;
    int          nb = 0;
    int          gap_cnt = -1;
    int          cur_gap = -1;
    logic [16:0] sh = '0;
    rx_t         rec;
    forever begin
      @(negedge clk_in);
      if (rst) begin
        in_frame = 0; prev_sclk = 0; low_cnt = 0; nb = 0; gap_cnt = -1; sh = '0;
      end else begin
        if (!spi_cs) begin
          if (!in_frame) begin
            in_frame = 1; low_cnt = 0; nb = 0; sh = '0; cur_gap = gap_cnt;
          end
          low_cnt++;
          low_total++;
          if (spi_clk && !prev_sclk) begin
            sh = {sh[15:0], spi_mosi};
            nb++;
            rise_total++;
          end
        end else begin
          if (in_frame) begin
            rec.data = sh; rec.nbits = nb; rec.low_cyc = low_cnt; rec.gap = cur_gap;
            rx_q.push_back(rec);
            in_frame = 0;
            gap_cnt = 0;
          end
          if (gap_cnt >= 0) gap_cnt++;
        end
        prev_sclk = spi_clk;
      end
    end
  end

  task automatic send(input logic [2:0] ch, input logic [11:0] d, input bit accept);
    smp_valid = 1'b1;
    smp_ch    = ch;
    smp_data  = d;
    if (accept) exp_q.push_back(exp_frame(ch, d));
    @(negedge clk_in);
  endtask

  task automatic wait_rx(input int n, output bit ok);
    int budget;
    budget = n * FRAME_TO;
    while (rx_q.size() < n && budget > 0) begin
      @(negedge clk_in);
      budget--;
    end
    ok = (rx_q.size() >= n);
  endtask

  task automatic wait_cs_low(output bit ok);
    int budget;
    budget = 50;
    while (spi_cs !== 1'b0 && budget > 0) begin
      @(negedge clk_in);
      budget--;
    end
    ok = (spi_cs === 1'b0);
  endtask

  task automatic test_reset;
    @(negedge clk_in);
    vec_cnt++;
    if ({spi_cs, spi_clk, spi_mosi, miso_last, overflow} !== 5'b10000 || fifo_level !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: cs/clk/mosi/miso_last/ovf=%b level=%0d, required 10000 level=0",
               {spi_cs, spi_clk, spi_mosi, miso_last, overflow}, fifo_level);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk_in);
    vec_cnt++;
    if (spi_cs !== 1'b1 || spi_clk !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL idle_after_reset: cs=%b clk=%b, required cs=1 clk=0", spi_cs, spi_clk);
    end
  endtask

  task automatic test_single;
    bit ok;
    rx_t r;
    logic [16:0] e;
    spi_miso = 1'b1;
    send(3'd0, 12'hA5C, 1'b1);
    smp_valid = 1'b0;
    vec_cnt++;
    if (fifo_level !== 4'd1) begin
      miscompares++;
      $display("[TB] FAIL single_level_push: got %0d, required 1", fifo_level);
    end
    @(negedge clk_in);
    vec_cnt++;
    if (fifo_level !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL single_level_pop: got %0d, required 0", fifo_level);
    end
    wait_rx(1, ok);
    vec_cnt++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL single_timeout: frames seen %0d, required 1", rx_q.size());
    end else begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      vec_cnt++;
      if (r.data !== e || r.nbits != FW) begin
        miscompares++;
        $display("[TB] FAIL single_frame: got %h (%0d bits), required %h (%0d bits)", r.data, r.nbits, e, FW);
      end
      vec_cnt++;
      if (r.low_cyc != CS_LOW) begin
        miscompares++;
        $display("[TB] FAIL single_cs_low: got %0d cycles, required %0d", r.low_cyc, CS_LOW);
      end
    end
    vec_cnt++;
    if (overflow !== 1'b0 || miso_last !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL single_flags: ovf=%b miso_last=%b, required ovf=0 miso_last=1", overflow, miso_last);
    end
    repeat (20) @(negedge clk_in);
  endtask

  task automatic test_word_1001;
    bit ok;
    rx_t r;
    logic [16:0] e;
    send(3'd1, 12'h001, 1'b1);
    smp_valid = 1'b0;
    wait_rx(1, ok);
    vec_cnt++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL w1001_timeout: frames seen %0d, required 1", rx_q.size());
    end else begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      vec_cnt++;
      if (r.data !== e || r.nbits != FW || r.low_cyc != CS_LOW) begin
        miscompares++;
        $display("[TB] FAIL w1001_frame: got %h/%0d bits/%0d low, required %h/%0d bits/%0d low",
                 r.data, r.nbits, r.low_cyc, e, FW, CS_LOW);
      end
    end
    repeat (20) @(negedge clk_in);
  endtask

  task automatic test_back_to_back;
    bit ok;
    rx_t r;
    logic [16:0] e;
    spi_miso = 1'b0;
    for (int i = 0; i < 8; i++) send(3'(i), 12'(i * 12'h111), 1'b1);
    smp_valid = 1'b0;
    vec_cnt++;
    if (fifo_level !== 4'd7) begin
      miscompares++;
      $display("[TB] FAIL b2b_level: got %0d, required 7", fifo_level);
    end
    wait_rx(8, ok);
    vec_cnt++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL b2b_timeout: frames seen %0d, required 8", rx_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        r = rx_q.pop_front();
        e = exp_q.pop_front();
        vec_cnt++;
        if (r.data !== e || r.nbits != FW) begin
          miscompares++;
          $display("[TB] FAIL b2b_frame%0d: got %h, required %h", i, r.data, e);
        end
        if (i > 0) begin
          vec_cnt++;
          if (r.gap != CS_GAP) begin
            miscompares++;
            $display("[TB] FAIL b2b_gap%0d: got %0d cycles, required %0d", i, r.gap, CS_GAP);
          end
        end
      end
    end
    vec_cnt++;
    if (miso_last !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_miso_last: got %b, required 0", miso_last);
    end
    repeat (20) @(negedge clk_in);
  endtask

  task automatic test_overflow;
    bit ok;
    rx_t r;
    logic [16:0] e;
    send(3'd5, 12'h3FF, 1'b1);
    smp_valid = 1'b0;
    wait_cs_low(ok);
    for (int i = 0; i < 10; i++) send(3'(i), 12'h300 + 12'(i), i < DEPTH);
    smp_valid = 1'b0;
    vec_cnt++;
    if (fifo_level !== 4'(DEPTH) || overflow !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ovf_set: level=%0d ovf=%b, required level=%0d ovf=1", fifo_level, overflow, DEPTH);
    end
    repeat (5) @(negedge clk_in);
    vec_cnt++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ovf_sticky: got %b, required 1", overflow);
    end
    clr_ovf = 1'b1;
    send(3'd7, 12'hBAD, 1'b0);
    smp_valid = 1'b0;
    clr_ovf = 1'b0;
    vec_cnt++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ovf_set_wins: got %b, required 1", overflow);
    end
    clr_ovf = 1'b1;
    @(negedge clk_in);
    clr_ovf = 1'b0;
    vec_cnt++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ovf_clear: got %b, required 0", overflow);
    end
    wait_rx(DEPTH + 1, ok);
    vec_cnt++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL ovf_timeout: frames seen %0d, required %0d", rx_q.size(), DEPTH + 1);
    end else begin
      for (int i = 0; i < DEPTH + 1; i++) begin
        r = rx_q.pop_front();
        e = exp_q.pop_front();
        vec_cnt++;
        if (r.data !== e) begin
          miscompares++;
          $display("[TB] FAIL ovf_frame%0d: got %h, required %h", i, r.data, e);
        end
      end
    end
    repeat (20) @(negedge clk_in);
  endtask

  task automatic test_push_pop_full;
    bit ok;
    int budget;
    rx_t r;
    logic [16:0] e;
    send(3'd2, 12'h0F0, 1'b1);
    smp_valid = 1'b0;
    wait_cs_low(ok);
    for (int i = 0; i < DEPTH; i++) send(3'(7 - i), 12'h5A0 + 12'(i), 1'b1);
    smp_valid = 1'b0;
    vec_cnt++;
    if (fifo_level !== 4'(DEPTH) || overflow !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ppf_fill: level=%0d ovf=%b, required level=%0d ovf=0", fifo_level, overflow, DEPTH);
    end
    budget = FRAME_TO;
    while (spi_cs !== 1'b1 && budget > 0) begin
      @(negedge clk_in);
      budget--;
    end
    repeat (GAP_CYC) @(negedge clk_in);
    send(3'd0, 12'hC3C, 1'b1);
    smp_valid = 1'b0;
    vec_cnt++;
    if (fifo_level !== 4'(DEPTH) || overflow !== 1'b0 || spi_cs !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ppf_same_cycle: level=%0d ovf=%b cs=%b, required level=%0d ovf=0 cs=0",
               fifo_level, overflow, spi_cs, DEPTH);
    end
    wait_rx(DEPTH + 2, ok);
    vec_cnt++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL ppf_timeout: frames seen %0d, required %0d", rx_q.size(), DEPTH + 2);
    end else begin
      for (int i = 0; i < DEPTH + 2; i++) begin
        r = rx_q.pop_front();
        e = exp_q.pop_front();
        vec_cnt++;
        if (r.data !== e) begin
          miscompares++;
          $display("[TB] FAIL ppf_frame%0d: got %h, required %h", i, r.data, e);
        end
      end
    end
    repeat (20) @(negedge clk_in);
  endtask

  task automatic test_reset_mid;
    int base;
    int budget;
    int low_base;
    send(3'd3, 12'h777, 1'b0);
    send(3'd4, 12'h888, 1'b0);
    send(3'd6, 12'h999, 1'b0);
    smp_valid = 1'b0;
    base = rise_total;
    budget = FRAME_TO;
    while (rise_total < base + 5 && budget > 0) begin
      @(negedge clk_in);
      budget--;
    end
    vec_cnt++;
    if (rise_total < base + 5) begin
      miscompares++;
      $display("[TB] FAIL rstmid_timeout: rising edges %0d, required 5", rise_total - base);
    end
    #1 rst = 1'b1;
    #1;
    vec_cnt++;
    if (spi_cs !== 1'b1 || spi_clk !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rstmid_async: cs=%b clk=%b, required cs=1 clk=0", spi_cs, spi_clk);
    end
    repeat (3) @(negedge clk_in);
    vec_cnt++;
    if (fifo_level !== '0 || overflow !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rstmid_flush: level=%0d ovf=%b, required level=0 ovf=0", fifo_level, overflow);
    end
    rst = 1'b0;
    exp_q.delete();
    low_base = low_total;
    repeat (2 * FRAME_TO) @(negedge clk_in);
    vec_cnt++;
    if (low_total != low_base || rx_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL rstmid_no_frames: cs low cycles %0d frames %0d, required 0 and 0",
               low_total - low_base, rx_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_word_1001();
    test_back_to_back();
    test_overflow();
    test_push_pop_full();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
